// File: rtl/perspective_mapper_if.sv
// perspective_mapper_if: request, result and coefficient bus
// slave side faces the mapper, master side faces the driver
interface perspective_mapper_if #(
  parameter int PIX_W  = 10,
  parameter int GRID_W = 7,
  parameter int W      = 33
);
  logic                    i_valid;
  logic                    o_ready;
  logic [2*PIX_W-1:0]      i_pixel;
  logic                    i_coef_we;
  logic [2:0]              i_coef_sel;
  logic signed [W-1:0]     i_coef_data;
  logic                    i_coef_commit;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_inside;
  logic [2*GRID_W-1:0]     o_point;

  modport slave (
    input  i_valid, i_pixel,
    input  i_coef_we, i_coef_sel,
    input  i_coef_data, i_coef_commit,
    input  i_ready,
    output o_ready, o_valid,
    output o_inside, o_point
  );

  modport master (
    output i_valid, i_pixel,
    output i_coef_we, i_coef_sel,
    output i_coef_data, i_coef_commit,
    output i_ready,
    input  o_ready, o_valid,
    input  o_inside, o_point
  );
endinterface

// File: rtl/perspective_mapper.sv
// perspective_mapper: projective pixel-to-grid mapper
// multiply, sum, restoring divide, half-up round, range check
module perspective_mapper #(
  parameter int INT_W    = 20,
  parameter int FRAC_W   = 13,
  parameter int PIX_W    = 10,
  parameter int GRID_W   = 7,
  parameter int GRID_MAX = 99
) (
  input logic i_clk,
  input logic i_rst,
  perspective_mapper_if.slave bus
);
  localparam int W  = INT_W + FRAC_W;
  localparam int SW = W + 2;
  localparam int PW = W + PIX_W + 1;
  localparam int QW = GRID_W + 2;
  localparam int DW = SW + QW + 1;
  localparam int CW = $clog2(QW + 1);

  localparam logic signed [W-1:0] MAX_C =
    {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_C =
    {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] ONE_W =
    W'(1) << FRAC_W;
  localparam logic signed [SW-1:0] ONE =
    SW'(1) << FRAC_W;

  typedef enum logic [2:0] {
    IDLE, MUL, SUM, DIV, DONE
  } state_t;

  state_t st;

  logic signed [W-1:0] sh    [8];
  logic signed [W-1:0] act   [8];
  logic signed [W-1:0] sh_nx [8];
  logic signed [W-1:0] prod  [6];
  logic                pend;
  logic [PIX_W-1:0]    px, py;
  logic signed [SW-1:0] sx, sy, sr;
  logic [DW-1:0]       rx, ry, dv;
  logic                ovx, ovy, neg;
  logic [QW-2:0]       qx, qy;
  logic [CW-1:0]       cnt;

  logic                acc, to_idle, cpy;
  logic [DW-1:0]       d0, nx0, ny0, ds;
  logic                bx, by, in_ok;
  logic [QW-1:0]       fqx, fqy, gx, gy;

  function automatic logic signed [W-1:0] sat(
    input logic signed [W-1:0] c,
    input logic [PIX_W-1:0]    p
  );
    logic signed [PW-1:0] f;
    f = PW'(c) * PW'($signed({1'b0, p}));
    if (&f[PW-1:W-1] || ~|f[PW-1:W-1])
      return f[W-1:0];
    return f[PW-1] ? MIN_C : MAX_C;
  endfunction

  function automatic logic signed [SW-1:0] ext(
    input logic signed [W-1:0] v
  );
    return {{2{v[W-1]}}, v};
  endfunction

  function automatic logic [DW-1:0] mag(
    input logic signed [SW-1:0] v
  );
    logic [SW-1:0] a;
    a = v[SW-1] ? -v : v;
    return DW'(a);
  endfunction

  // shadow set with this cycle's write folded in
  always_comb begin
    sh_nx = sh;
    if (bus.i_coef_we)
      sh_nx[bus.i_coef_sel] = bus.i_coef_data;
  end

  assign acc     = (st == IDLE) && bus.i_valid;
  assign to_idle = (st == DONE) && bus.i_ready;
  // a commit racing an accept waits for the next IDLE
  assign cpy = ((st == IDLE) && bus.i_coef_commit && !acc)
            || (to_idle && (pend || bus.i_coef_commit));

  assign bus.o_ready = (st == IDLE);

  // non-positive R never divides: use 1, result is dropped
  assign d0  = (!sr[SW-1] && sr != '0) ? mag(sr) : DW'(1);
  assign nx0 = mag(sx) << 1;
  assign ny0 = mag(sy) << 1;

  // one restoring step plus rounding of the final quotient
  always_comb begin
    ds    = dv >> 1;
    bx    = rx >= ds;
    by    = ry >= ds;
    fqx   = {qx, bx};
    fqy   = {qy, by};
    gx    = QW'(fqx[QW-1:1]) + QW'(fqx[0]);
    gy    = QW'(fqy[QW-1:1]) + QW'(fqy[0]);
    in_ok = !neg && !ovx && !ovy
         && gx <= QW'(GRID_MAX)
         && gy <= QW'(GRID_MAX);
  end

  // coefficient banks, request FSM and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st           <= IDLE;
      pend         <= 1'b0;
      px           <= '0;
      py           <= '0;
      sx           <= '0;
      sy           <= '0;
      sr           <= '0;
      rx           <= '0;
      ry           <= '0;
      dv           <= '0;
      ovx          <= 1'b0;
      ovy          <= 1'b0;
      neg          <= 1'b0;
      qx           <= '0;
      qy           <= '0;
      cnt          <= '0;
      bus.o_valid  <= 1'b0;
      bus.o_inside <= 1'b0;
      bus.o_point  <= '0;
      for (int k = 0; k < 8; k++) begin
        sh[k]  <= (k == 0 || k == 4) ? ONE_W : '0;
        act[k] <= (k == 0 || k == 4) ? ONE_W : '0;
      end
      for (int k = 0; k < 6; k++)
        prod[k] <= '0;
    end else begin
      sh <= sh_nx;
      if (cpy)
        act <= sh_nx;
      pend <= cpy ? 1'b0 : (pend | bus.i_coef_commit);
      unique case (st)
        IDLE: begin
          if (acc) begin
            px <= bus.i_pixel[2*PIX_W-1:PIX_W];
            py <= bus.i_pixel[PIX_W-1:0];
            st <= MUL;
          end
        end
        MUL: begin
          prod[0] <= sat(act[0], px);
          prod[1] <= sat(act[1], py);
          prod[2] <= sat(act[3], px);
          prod[3] <= sat(act[4], py);
          prod[4] <= sat(act[6], px);
          prod[5] <= sat(act[7], py);
          st      <= SUM;
        end
        SUM: begin
          sx  <= ext(prod[0]) + ext(prod[1]) + ext(act[2]);
          sy  <= ext(prod[2]) + ext(prod[3]) + ext(act[5]);
          sr  <= ext(prod[4]) + ext(prod[5]) + ONE;
          cnt <= '0;
          st  <= DIV;
        end
        DIV: begin
          cnt <= cnt + CW'(1);
          if (cnt == '0) begin
            rx  <= nx0;
            ry  <= ny0;
            dv  <= d0 << QW;
            ovx <= nx0 >= (d0 << QW);
            ovy <= ny0 >= (d0 << QW);
            neg <= sr[SW-1] || sr == '0
                || sx[SW-1] || sy[SW-1];
            qx  <= '0;
            qy  <= '0;
          end else begin
            rx <= bx ? rx - ds : rx;
            ry <= by ? ry - ds : ry;
            dv <= ds;
            qx <= fqx[QW-2:0];
            qy <= fqy[QW-2:0];
            if (cnt == CW'(QW)) begin
              bus.o_valid  <= 1'b1;
              bus.o_inside <= in_ok;
              bus.o_point  <= in_ok
                ? {gx[GRID_W-1:0], gy[GRID_W-1:0]}
                : '0;
              st <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
            st          <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
